pmod_jstk_responder: RTL

//  SPI mode-0 responder that models the PmodJSTK joystick peripheral, the far end of the joystick SPI master.

---
 rtl/jstk_pkg.sv | 33 +++
 rtl/pmod_jstk_responder_if.sv | 26 ++
 rtl/spi_edge_sync.sv | 31 +++
 rtl/pmod_jstk_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared constants, state type and frame-byte layout for the PmodJSTK SPI responder.
package jstk_pkg;

  localparam int unsigned JSTK_FRAME_BYTES  = 5;
  localparam int unsigned JSTK_CMD_FLAG_BIT = 7;

  localparam logic [2:0] JSTK_B_XLO = 3'd0;
  localparam logic [2:0] JSTK_B_XHI = 3'd1;
  localparam logic [2:0] JSTK_B_YLO = 3'd2;
  localparam logic [2:0] JSTK_B_YHI = 3'd3;
  localparam logic [2:0] JSTK_B_BTN = 3'd4;

  typedef enum logic [0:0] {
    IDLE,
    ACTIVE
  } jstk_rsp_state_t;

  function automatic logic [7:0] jstk_frame_byte(input logic [9:0] x, input logic [9:0] y,
                                                 input logic [2:0] btn, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      JSTK_B_XLO: b = x[7:0];
      JSTK_B_XHI: b = {6'b0, x[9:8]};
      JSTK_B_YLO: b = y[7:0];
      JSTK_B_YHI: b = {6'b0, y[9:8]};
      JSTK_B_BTN: b = {5'b0, btn};
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pmod_jstk_responder_if.sv
// SPI pin bundle between the joystick master and the PmodJSTK responder.
interface pmod_jstk_responder_if;

  logic ss;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output ss,
    output sclk,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  ss,
    input  sclk,
    input  mosi,
    output miso,
    output miso_oe
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin, plus registered-history edge pulses.
module spi_edge_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  // Chain and history reset low so a pin already low at reset release yields no fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = sync_q[SyncStages-1] & ~prev_q;
  assign fall_o  = ~sync_q[SyncStages-1] & prev_q;

endmodule

// File: rtl/pmod_jstk_responder.sv
// PmodJSTK SPI mode-0 responder: snapshots X/Y/buttons per frame and captures the command byte.
// Define JSTK_RSP_LED_EN to let command bytes with bit 7 set drive the LED outputs.
module pmod_jstk_responder
  import jstk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_BYTES   = JSTK_FRAME_BYTES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [9:0]                  x_i,
  input  logic [9:0]                  y_i,
  input  logic [2:0]                  btn_i,
  pmod_jstk_responder_if.slave        spi,
  output logic [1:0]                  led_o,
  output logic [7:0]                  cmd_byte_o,
  output logic                        cmd_valid_o,
  output logic                        xfer_done_o,
  output logic                        busy_o
);

  logic ss_rise, ss_fall, ss_lvl;
  logic sclk_rise, sclk_fall, sclk_lvl;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_edge_sync #(.SyncStages(SYNC_STAGES)) u_sync_ss (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi.ss),
    .level_o(ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_edge_sync #(.SyncStages(SYNC_STAGES)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi.sclk),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_edge_sync #(.SyncStages(SYNC_STAGES)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi.mosi),
    .level_o(mosi_lvl),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  jstk_rsp_state_t state_q, state_d;
  logic [9:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [2:0] snap_btn_q, snap_btn_d;
  logic [7:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_next;
  logic [2:0] bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       cmd_valid_q, cmd_valid_d, xfer_done_q, xfer_done_d;

  function automatic logic [7:0] frame_byte(input logic [9:0] x, input logic [9:0] y,
                                            input logic [2:0] btn, input logic [2:0] idx);
    if (32'(idx) >= NUM_BYTES) return 8'h00;
    return jstk_frame_byte(x, y, btn, idx);
  endfunction

  assign rx_next = {rx_sr_q[6:0], mosi_lvl};

  always_comb begin
    state_d     = state_q;
    snap_x_d    = snap_x_q;
    snap_y_d    = snap_y_q;
    snap_btn_d  = snap_btn_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    xfer_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          snap_x_d   = x_i;
          snap_y_d   = y_i;
          snap_btn_d = btn_i;
          tx_sr_d    = frame_byte(x_i, y_i, btn_i, JSTK_B_XLO);
          rx_sr_d    = 8'h00;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 3'd0;
        end
      end
      ACTIVE: begin
        // SS rise has priority over any SCLK edge seen in the same cycle.
        if (ss_rise) begin
          state_d     = IDLE;
          tx_sr_d     = 8'h00;
          xfer_done_d = (32'(byte_cnt_q) >= NUM_BYTES);
        end else if (sclk_rise) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q != 3'd7) byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd0) begin
              cmd_byte_d  = rx_next;
              cmd_valid_d = 1'b1;
            end
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == 3'd0) begin
            tx_sr_d = frame_byte(snap_x_q, snap_y_q, snap_btn_q, byte_cnt_q);
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      snap_btn_q  <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      cmd_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_x_q    <= snap_x_d;
      snap_y_q    <= snap_y_d;
      snap_btn_q  <= snap_btn_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      xfer_done_q <= xfer_done_d;
    end
  end

`ifdef JSTK_RSP_LED_EN
  logic [1:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (cmd_valid_d && cmd_byte_d[JSTK_CMD_FLAG_BIT]) led_d = cmd_byte_d[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) led_q <= 2'b00;
    else       led_q <= led_d;
  end

  assign led_o = led_q;
`else
  assign led_o = 2'b00;
`endif

  // tx_sr is cleared whenever the frame ends, so MISO idles low.
  assign spi.miso    = tx_sr_q[7];
  assign spi.miso_oe = (state_q == ACTIVE);
  assign busy_o      = (state_q == ACTIVE);
  assign cmd_byte_o  = cmd_byte_q;
  assign cmd_valid_o = cmd_valid_q;
  assign xfer_done_o = xfer_done_q;

endmodule
